fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Fetch and sequencing controller for the picoMIPS program memory. Owns the program counter, drives the program-memory address, captures the returned instruction into a one-entry instruction register (IR), and resolves halt, I/O-wait, jump and relative-branch requests from the decoder. Sits between the program memory (asynchronous read) and the decoder/datapath in the CPU top level.

## Interface

Parameters:
- I_SIZE, 24: instruction width.
- P_SIZE, 6: program address width. Memory depth is 2^P_SIZE.

Ports:
- clk  in  1  single clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high. One clock; reset is synchronous and active-high.
- startIn  in  1  leave IDLE/HALTED and begin execution at address 0.
- instructionIn  in  I_SIZE  program-memory data for addressOut, same cycle.
- addressOut  out  P_SIZE  program-memory address. Always equals PC.
- irOut  out  I_SIZE  instruction in IR, presented to the decoder.
- irValidOut  out  1  irOut holds a live instruction.
- haltIn  in  1  decoder: IR is a halt instruction.
- waitIn  in  1  decoder: IR needs external input before it completes.
- jumpIn  in  1  decoder: absolute jump.
- jumpAddrIn  in  P_SIZE  jump target.
- branchIn  in  1  decoder: taken relative branch.
- branchOffsetIn  in  P_SIZE  signed two's-complement offset, relative to the IR address.
- ioAckIn  in  1  external input ready; completes a waiting instruction.
- ioReqOut  out  1  high while in WAIT.
- commitOut  out  1  IR instruction completes this cycle.
- stateOut  out  2  current FSM state.

## Operation

- States: IDLE=0, RUN=1, WAIT=2, HALTED=3.
- Registers: PC, IR, irAddr (address of IR), irValid, state.
- Decoder inputs (halt/wait/jump/branch) are honoured only in RUN with irValid=1. Otherwise they are ignored.
- IDLE or HALTED with startIn: IR<=instructionIn at PC=0, so addressOut must be 0 in these states. Then irAddr<=0, PC<=1, irValid<=1, state<=RUN. Without startIn, all registers hold.
- RUN with irValid=1. Priority is halt > wait > jump > branch > sequential:
  - haltIn: state<=HALTED, irValid<=0, PC<=0. commitOut=1.
  - waitIn: state<=WAIT. PC, IR and irAddr hold. commitOut=0.
  - jumpIn: PC<=jumpAddrIn, irValid<=0. The in-flight fetch is squashed. commitOut=1.
  - branchIn: PC<=(irAddr + sign-extended branchOffsetIn) mod 2^P_SIZE, irValid<=0. commitOut=1.
  - Otherwise (sequential): IR<=instructionIn, irAddr<=PC, PC<=PC+1 mod 2^P_SIZE, irValid<=1. commitOut=1.
- RUN with irValid=0 (bubble): sequential load. commitOut=0.
- WAIT: ioReqOut=1.
  - With ioAckIn: commitOut=1, sequential load, state<=RUN.
  - Without ioAckIn: everything holds.
- ioAckIn outside WAIT is ignored.
- waitIn together with jumpIn or branchIn is illegal. Wait wins; the bench asserts it never occurs.
- Arithmetic is unsigned modulo 2^P_SIZE. PC 63+1 wraps to 0 at P_SIZE=6. Branch targets wrap both ways.

## Timing

- Reset values: PC=0, IR=0, irAddr=0, irValid=0, state=IDLE. So addressOut=0, irOut=0, irValidOut=0, ioReqOut=0, commitOut=0, stateOut=0.
- Reset asserted in any state, including WAIT, returns to IDLE at that edge. ioReqOut is low from the next cycle.
- startIn to first irValidOut: 1 cycle.
- Sequential throughput: one commit per cycle.
- Taken jump or branch: exactly one bubble cycle (irValidOut=0). The target instruction is in IR 2 cycles after the request.
- WAIT entry: 1 cycle after waitIn. Completion is in the cycle ioAckIn is seen; the next instruction follows in IR the cycle after.
- commitOut, ioReqOut and addressOut are combinational from registers and same-cycle inputs. There are no memory-to-output combinational paths except instructionIn→IR.

## Structure

- Shared picomips package holds:
  - fetch_state_t enum (IDLE, RUN, WAIT, HALTED; 2-bit encoding as above).
  - RESET_VECTOR = 0.
- No sub-module. The top level wires addressOut to programMemory.addressIn and programMemory.instructionOut to instructionIn.
- Single always_ff for state, PC and IR. Single always_comb for next-state/next-PC selection.

## Test plan

- Reset then startIn pulse, with memory holding sequential non-control words:
  - irValidOut rises 1 cycle later with irOut=mem[0].
  - addressOut steps 1,2,3…
  - commitOut=1 every cycle.
- jumpIn with jumpAddrIn=40 while IR at address 5:
  - Next cycle irValidOut=0, addressOut=40.
  - Following cycle irOut=mem[40], irAddr=40.
- branchIn with offset 6'b111110 (−2) at irAddr=1: PC becomes 63 (wrap). Also branch +3 at irAddr=62: PC becomes 1.
- waitIn held for 4 cycles, then ioAckIn:
  - ioReqOut=1 for 4 cycles, PC/IR frozen, commitOut=0.
  - Ack cycle: commitOut=1. Next IR = following address.
- haltIn at address 10:
  - stateOut=3, irValidOut=0, addressOut=0.
  - Decoder and ioAckIn inputs ignored.
  - startIn restarts with irOut=mem[0].
- reset asserted mid-WAIT and at PC=63: next cycle all outputs at reset values, stateOut=0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the picoMIPS fetch/sequencing controller.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam int RESET_VECTOR = 0;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Program-memory, decoder and I/O handshake signals of the fetch sequencer.
interface fetch_sequencer_if #(
  parameter int I_SIZE = 24,
  parameter int P_SIZE = 6
);

  logic              startIn;
  logic [I_SIZE-1:0] instructionIn;
  logic [P_SIZE-1:0] addressOut;
  logic [I_SIZE-1:0] irOut;
  logic              irValidOut;
  logic              haltIn;
  logic              waitIn;
  logic              jumpIn;
  logic [P_SIZE-1:0] jumpAddrIn;
  logic              branchIn;
  logic [P_SIZE-1:0] branchOffsetIn;
  logic              ioAckIn;
  logic              ioReqOut;
  logic              commitOut;
  logic [1:0]        stateOut;

  // The sequencer side.
  modport master (
    input  startIn, instructionIn, haltIn, waitIn, jumpIn, jumpAddrIn,
           branchIn, branchOffsetIn, ioAckIn,
    output addressOut, irOut, irValidOut, ioReqOut, commitOut, stateOut
  );

  // Memory, decoder and I/O side.
  modport slave (
    output startIn, instructionIn, haltIn, waitIn, jumpIn, jumpAddrIn,
           branchIn, branchOffsetIn, ioAckIn,
    input  addressOut, irOut, irValidOut, ioReqOut, commitOut, stateOut
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Fetch and sequencing controller: owns the PC, the one-entry IR and the
// halt / I/O-wait / jump / branch resolution for picoMIPS.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int I_SIZE = 24,
  parameter int P_SIZE = 6
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);

  localparam logic [P_SIZE-1:0] RESET_PC = P_SIZE'(RESET_VECTOR);
  localparam logic [P_SIZE-1:0] PC_STEP  = P_SIZE'(1);

  fetch_state_t      state_q, state_d;
  logic [P_SIZE-1:0] pc_q, pc_d;
  logic [P_SIZE-1:0] irAddr_q, irAddr_d;
  logic [I_SIZE-1:0] ir_q, ir_d;
  logic              irValid_q, irValid_d;
  logic              commit, ioReq;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      irAddr_q  <= RESET_PC;
      ir_q      <= '0;
      irValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      irAddr_q  <= irAddr_d;
      ir_q      <= ir_d;
      irValid_q <= irValid_d;
    end
  end

  // Sign extension of the offset is implicit: adding it modulo 2^P_SIZE
  // gives the same result as a sign-extended add truncated to P_SIZE.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    irAddr_d  = irAddr_q;
    ir_d      = ir_q;
    irValid_d = irValid_q;
    commit    = 1'b0;
    ioReq     = 1'b0;

    case (state_q)
      IDLE, HALTED: begin
        if (bus.startIn) begin
          ir_d      = bus.instructionIn;
          irAddr_d  = RESET_PC;
          pc_d      = RESET_PC + PC_STEP;
          irValid_d = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (irValid_q && bus.haltIn) begin
          commit    = 1'b1;
          state_d   = HALTED;
          irValid_d = 1'b0;
          pc_d      = RESET_PC;
        end else if (irValid_q && bus.waitIn) begin
          state_d = WAIT;
        end else if (irValid_q && bus.jumpIn) begin
          commit    = 1'b1;
          pc_d      = bus.jumpAddrIn;
          irValid_d = 1'b0;
        end else if (irValid_q && bus.branchIn) begin
          commit    = 1'b1;
          pc_d      = irAddr_q + bus.branchOffsetIn;
          irValid_d = 1'b0;
        end else begin
          commit    = irValid_q;
          ir_d      = bus.instructionIn;
          irAddr_d  = pc_q;
          pc_d      = pc_q + PC_STEP;
          irValid_d = 1'b1;
        end
      end

      WAIT: begin
        ioReq = 1'b1;
        if (bus.ioAckIn) begin
          commit    = 1'b1;
          ir_d      = bus.instructionIn;
          irAddr_d  = pc_q;
          pc_d      = pc_q + PC_STEP;
          irValid_d = 1'b1;
          state_d   = RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.addressOut = pc_q;
  assign bus.irOut      = ir_q;
  assign bus.irValidOut = irValid_q;
  assign bus.ioReqOut   = ioReq;
  assign bus.commitOut  = commit;
  assign bus.stateOut   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a behavioural program memory.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int I_SIZE = 24;
  localparam int P_SIZE = 6;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [I_SIZE-1:0] mem [64];

  fetch_sequencer_if #(.I_SIZE(I_SIZE), .P_SIZE(P_SIZE)) bus ();

  fetch_sequencer #(.I_SIZE(I_SIZE), .P_SIZE(P_SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Asynchronous-read program memory.
  assign bus.instructionIn = mem[bus.addressOut];

  // Wait combined with jump or branch is illegal stimulus.
  always @(negedge clk) begin
    assert (!(bus.waitIn && (bus.jumpIn || bus.branchIn))) else begin
      errors++;
      $error("[TB] FAIL illegalCombo observed wait with jump/branch expected none");
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic halt, input logic waitI,
                               input logic jump, input logic [5:0] jaddr,
                               input logic branch, input logic [5:0] boff,
                               input logic ack);
    bus.startIn        = start;
    bus.haltIn         = halt;
    bus.waitIn         = waitI;
    bus.jumpIn         = jump;
    bus.jumpAddrIn     = jaddr;
    bus.branchIn       = branch;
    bus.branchOffsetIn = boff;
    bus.ioAckIn        = ack;
    #1;
  endtask

  task automatic clearInputs();
    applyStimulus(0, 0, 0, 0, 6'd0, 0, 6'd0, 0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [5:0] addr, input logic [23:0] ir,
                          input logic valid, input logic ioReq, input logic commit,
                          input logic [1:0] st);
    checkOutput({tag, ".addr"},   32'(bus.addressOut), 32'(addr));
    checkOutput({tag, ".ir"},     32'(bus.irOut),      32'(ir));
    checkOutput({tag, ".valid"},  32'(bus.irValidOut), 32'(valid));
    checkOutput({tag, ".ioReq"},  32'(bus.ioReqOut),   32'(ioReq));
    checkOutput({tag, ".commit"}, 32'(bus.commitOut),  32'(commit));
    checkOutput({tag, ".state"},  32'(bus.stateOut),   32'(st));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 24'hC30000 + 24'(i);

    reset = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkAll("reset", 6'd0, 24'h0, 0, 0, 0, 2'd0);

    applyStimulus(0, 0, 0, 0, 6'd0, 0, 6'd0, 1);
    checkAll("idleAck", 6'd0, 24'h0, 0, 0, 0, 2'd0);

    applyStimulus(1, 0, 0, 0, 6'd0, 0, 6'd0, 0);
    checkAll("startReq", 6'd0, 24'h0, 0, 0, 0, 2'd0);
    nextCycle();
    clearInputs();
    checkAll("first", 6'd1, mem[0], 1, 0, 1, 2'd1);

    for (int i = 1; i <= 5; i++) begin
      nextCycle();
      checkAll("seq", 6'(i + 1), mem[i], 1, 0, 1, 2'd1);
    end

    applyStimulus(0, 0, 0, 1, 6'd40, 0, 6'd0, 0);
    checkAll("jumpReq", 6'd6, mem[5], 1, 0, 1, 2'd1);
    nextCycle();
    clearInputs();
    checkAll("jumpBubble", 6'd40, mem[5], 0, 0, 0, 2'd1);
    nextCycle();
    checkAll("jumpTarget", 6'd41, mem[40], 1, 0, 1, 2'd1);

    applyStimulus(0, 0, 0, 1, 6'd1, 0, 6'd0, 0);
    nextCycle();
    clearInputs();
    nextCycle();
    checkAll("atAddr1", 6'd2, mem[1], 1, 0, 1, 2'd1);
    applyStimulus(0, 0, 0, 0, 6'd0, 1, 6'b111110, 0);
    nextCycle();
    clearInputs();
    checkAll("branchNeg", 6'd63, mem[1], 0, 0, 0, 2'd1);
    nextCycle();
    checkAll("pcWrap", 6'd0, mem[63], 1, 0, 1, 2'd1);

    applyStimulus(0, 0, 0, 1, 6'd62, 0, 6'd0, 0);
    nextCycle();
    clearInputs();
    nextCycle();
    checkAll("atAddr62", 6'd63, mem[62], 1, 0, 1, 2'd1);
    applyStimulus(0, 0, 0, 0, 6'd0, 1, 6'd3, 0);
    nextCycle();
    clearInputs();
    checkAll("branchWrap", 6'd1, mem[62], 0, 0, 0, 2'd1);
    nextCycle();
    checkAll("branchTarget", 6'd2, mem[1], 1, 0, 1, 2'd1);

    applyStimulus(0, 0, 1, 0, 6'd0, 0, 6'd0, 0);
    checkAll("waitReq", 6'd2, mem[1], 1, 0, 0, 2'd1);
    nextCycle();
    for (int j = 0; j < 3; j++) begin
      checkAll("waiting", 6'd2, mem[1], 1, 1, 0, 2'd2);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 6'd0, 0, 6'd0, 1);
    checkAll("ackCycle", 6'd2, mem[1], 1, 1, 1, 2'd2);
    nextCycle();
    clearInputs();
    checkAll("afterAck", 6'd3, mem[2], 1, 0, 1, 2'd1);

    applyStimulus(0, 0, 0, 1, 6'd10, 0, 6'd0, 0);
    nextCycle();
    clearInputs();
    nextCycle();
    checkAll("atAddr10", 6'd11, mem[10], 1, 0, 1, 2'd1);
    applyStimulus(0, 1, 0, 0, 6'd0, 0, 6'd0, 0);
    checkAll("haltReq", 6'd11, mem[10], 1, 0, 1, 2'd1);
    nextCycle();
    applyStimulus(0, 1, 0, 1, 6'd20, 1, 6'd5, 1);
    checkAll("halted", 6'd0, mem[10], 0, 0, 0, 2'd3);
    nextCycle();
    checkAll("haltedHold", 6'd0, mem[10], 0, 0, 0, 2'd3);
    applyStimulus(1, 0, 0, 0, 6'd0, 0, 6'd0, 0);
    nextCycle();
    clearInputs();
    checkAll("restart", 6'd1, mem[0], 1, 0, 1, 2'd1);

    applyStimulus(0, 0, 1, 0, 6'd0, 0, 6'd0, 0);
    nextCycle();
    clearInputs();
    checkAll("waitAgain", 6'd1, mem[0], 1, 1, 0, 2'd2);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    #1;
    checkAll("resetWait", 6'd0, 24'h0, 0, 0, 0, 2'd0);

    applyStimulus(1, 0, 0, 0, 6'd0, 0, 6'd0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 6'd63, 0, 6'd0, 0);
    nextCycle();
    clearInputs();
    checkAll("at63", 6'd63, mem[0], 0, 0, 0, 2'd1);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    #1;
    checkAll("reset63", 6'd0, 24'h0, 0, 0, 0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
